// File: rtl/nios_mul_pipe_unit.sv
// Three-stage pipelined N x N multiplier with MUL/MULH/MULHSU/MULHU result select.
// Operands are split into N/2 halves so each stage-2 multiplier is only a half-width product.
module nios_mul_pipe_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int H = WIDTH / 2;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Valid semantics: an op enters on an edge with in_valid=1, en=1, flush=0; out_valid=1 means
    // stage 3 holds a result that is consumed on the next edge with en=1. en=0 freezes everything.

    // Stage 1: captured operands
    logic             v1_q;
    logic [1:0]       op1_q;
    logic [WIDTH-1:0] a1_q, b1_q;
    logic [TAG_W-1:0] tag1_q;

    // Stage 2: partial products plus what the high-word correction needs
    logic             v2_q;
    logic [1:0]       op2_q;
    logic [WIDTH-1:0] a2_q, b2_q;
    logic             a_sign2_q, b_sign2_q;
    logic [TAG_W-1:0] tag2_q;
    logic [WIDTH-1:0] p_ll_q, p_lh_q, p_hl_q, p_hh_q;
    logic [WIDTH-1:0] p_ll_d, p_lh_d, p_hl_d, p_hh_d;

    // Stage 3: selected result
    logic             v3_q;
    logic [WIDTH-1:0] res3_q, res3_d;
    logic [TAG_W-1:0] tag3_q;

    logic [2*WIDTH-1:0] u_full;
    logic [WIDTH-1:0]   u_hi, corr_a, corr_b;

    always_comb begin
        p_ll_d = WIDTH'(a1_q[H-1:0])     * WIDTH'(b1_q[H-1:0]);
        p_lh_d = WIDTH'(a1_q[H-1:0])     * WIDTH'(b1_q[WIDTH-1:H]);
        p_hl_d = WIDTH'(a1_q[WIDTH-1:H]) * WIDTH'(b1_q[H-1:0]);
        p_hh_d = WIDTH'(a1_q[WIDTH-1:H]) * WIDTH'(b1_q[WIDTH-1:H]);
    end

    // Signed high words come from the unsigned product minus the two's-complement corrections.
    always_comb begin
        u_full = (2*WIDTH)'(p_ll_q)
               + ((2*WIDTH)'(p_lh_q) << H)
               + ((2*WIDTH)'(p_hl_q) << H)
               + ((2*WIDTH)'(p_hh_q) << WIDTH);
        u_hi   = u_full[2*WIDTH-1:WIDTH];
        corr_a = a_sign2_q ? b2_q : '0;
        corr_b = b_sign2_q ? a2_q : '0;
        res3_d = u_full[WIDTH-1:0];
        case (op2_q)
            OP_MUL:    res3_d = u_full[WIDTH-1:0];
            OP_MULH:   res3_d = u_hi - corr_a - corr_b;
            OP_MULHSU: res3_d = u_hi - corr_a;
            OP_MULHU:  res3_d = u_hi;
            default:   res3_d = u_full[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q      <= 1'b0;
            op1_q     <= '0;
            a1_q      <= '0;
            b1_q      <= '0;
            tag1_q    <= '0;
            v2_q      <= 1'b0;
            op2_q     <= '0;
            a2_q      <= '0;
            b2_q      <= '0;
            a_sign2_q <= 1'b0;
            b_sign2_q <= 1'b0;
            tag2_q    <= '0;
            p_ll_q    <= '0;
            p_lh_q    <= '0;
            p_hl_q    <= '0;
            p_hh_q    <= '0;
            v3_q      <= 1'b0;
            res3_q    <= '0;
            tag3_q    <= '0;
        end else begin
            if (en) begin
                op1_q     <= in_op;
                a1_q      <= in_a;
                b1_q      <= in_b;
                tag1_q    <= in_tag;
                op2_q     <= op1_q;
                a2_q      <= a1_q;
                b2_q      <= b1_q;
                a_sign2_q <= a1_q[WIDTH-1];
                b_sign2_q <= b1_q[WIDTH-1];
                tag2_q    <= tag1_q;
                p_ll_q    <= p_ll_d;
                p_lh_q    <= p_lh_d;
                p_hl_q    <= p_hl_d;
                p_hh_q    <= p_hh_d;
                res3_q    <= res3_d;
                tag3_q    <= tag2_q;
            end
            // flush only kills valid bits; stale data behind a cleared valid is harmless
            if (flush) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
                v3_q <= 1'b0;
            end else if (en) begin
                v1_q <= in_valid;
                v2_q <= v1_q;
                v3_q <= v2_q;
            end
        end
    end

    assign out_valid  = v3_q;
    assign out_result = res3_q;
    assign out_tag    = tag3_q;
    assign busy       = v1_q | v2_q | v3_q;
endmodule

// File: tb/tb_nios_mul_pipe_unit.sv
// Bench for nios_mul_pipe_unit: directed corner cases on a 32-bit instance, then randomized
// traffic with random stall/flush on 32-bit and 16-bit instances against a product-level model.
module tb_nios_mul_pipe_unit;
    logic clk = 1'b0;
    logic reset, en, flush;

    logic        iv32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic [4:0]  tag32;
    logic        ov32, busy32;
    logic [31:0] res32;
    logic [4:0]  otag32;

    logic        iv16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic [4:0]  tag16;
    logic        ov16, busy16;
    logic [15:0] res16;
    logic [4:0]  otag16;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          dut;
        logic [31:0] res;
        logic [4:0]  tag;
        int          age;
    } flight_t;

    flight_t fq[$];

    always #5 clk = ~clk;

    nios_mul_pipe_unit #(.WIDTH(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(iv32), .in_op(op32), .in_a(a32), .in_b(b32), .in_tag(tag32),
        .out_valid(ov32), .out_result(res32), .out_tag(otag32), .busy(busy32)
    );

    nios_mul_pipe_unit #(.WIDTH(16), .TAG_W(5)) u_dut16 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(iv16), .in_op(op16), .in_a(a16), .in_b(b16), .in_tag(tag16),
        .out_valid(ov16), .out_result(res16), .out_tag(otag16), .busy(busy16)
    );

    // Mathematical product of the operands interpreted per op, reduced to the selected n-bit word.
    function automatic logic [31:0] ref_mul(input int n, input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [127:0]        m;
        logic signed [127:0] sa, sb, p, modv;
        m    = (128'd1 << n) - 128'd1;
        modv = $signed(128'd1 << n);
        sa   = $signed(128'(a) & m);
        sb   = $signed(128'(b) & m);
        if ((op == 2'b01 || op == 2'b10) && a[n-1]) sa = sa - modv;
        if (op == 2'b01 && b[n-1]) sb = sb - modv;
        p = sa * sb;
        if (op == 2'b00) return 32'(p & m);
        return 32'((p >>> n) & m);
    endfunction

    function automatic logic [31:0] rand_operand(input int n);
        logic [31:0] mask;
        mask = 32'((64'd1 << n) - 64'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (n - 1);
            3:       return (32'd1 << (n - 1)) - 32'd1;
            4:       return 32'd1;
            default: return $urandom() & mask;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iv32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0; tag32 = '0;
        iv16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0; tag16 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0;
        idle_inputs();
        repeat (2) tick();
        n_checks += 4;
        if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ov32); end
        if (res32 !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", res32); end
        if (otag32 !== 5'd0) begin n_fail++; $display("FAIL reset_tag got=%0d exp=0", otag32); end
        if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy32); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[4];
        logic [31:0] exp[4];
        ops[0] = 2'b00; ops[1] = 2'b11; ops[2] = 2'b01; ops[3] = 2'b10;
        exp[0] = 32'h00000001; exp[1] = 32'hFFFFFFFE; exp[2] = 32'h00000000; exp[3] = 32'hFFFFFFFF;
        en = 1'b1; flush = 1'b0;
        for (int c = 0; c < 7; c++) begin
            iv32 = (c < 4); op32 = (c < 4) ? ops[c] : 2'b00;
            a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; tag32 = 5'(c + 10);
            tick();
            n_checks++;
            if (c >= 2 && c <= 5) begin
                if (ov32 !== 1'b1 || res32 !== exp[c-2] || otag32 !== 5'(c + 8)) begin
                    n_fail++;
                    $display("FAIL b2b_op%0d got v=%b r=%h t=%0d exp v=1 r=%h t=%0d",
                             c - 2, ov32, res32, otag32, exp[c-2], c + 8);
                end
            end else if (ov32 !== 1'b0) begin
                n_fail++; $display("FAIL b2b_idle_c%0d got v=%b exp v=0", c, ov32);
            end
        end
        idle_inputs();
    endtask

    task automatic test_corners();
        logic [1:0]  ops[3];
        logic [31:0] as[3], bs[3], exp[3];
        ops[0] = 2'b01; as[0] = 32'h80000000; bs[0] = 32'h80000000; exp[0] = 32'h40000000;
        ops[1] = 2'b00; as[1] = 32'h80000000; bs[1] = 32'h80000000; exp[1] = 32'h00000000;
        ops[2] = 2'b01; as[2] = 32'h80000000; bs[2] = 32'h00000001; exp[2] = 32'hFFFFFFFF;
        en = 1'b1; flush = 1'b0;
        for (int c = 0; c < 5; c++) begin
            iv32 = (c < 3);
            op32 = (c < 3) ? ops[c] : 2'b00;
            a32  = (c < 3) ? as[c] : 32'd0;
            b32  = (c < 3) ? bs[c] : 32'd0;
            tag32 = 5'(c + 20);
            tick();
            if (c >= 2) begin
                n_checks++;
                if (ov32 !== 1'b1 || res32 !== exp[c-2] || otag32 !== 5'(c + 18)) begin
                    n_fail++;
                    $display("FAIL corner_%0d got v=%b r=%h t=%0d exp v=1 r=%h t=%0d",
                             c - 2, ov32, res32, otag32, exp[c-2], c + 18);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall();
        logic        s_en[10], s_iv[10];
        logic [4:0]  s_tag[10], s_exp[10];
        logic [31:0] ta[5], tb[5];
        logic [1:0]  top[5];
        logic [31:0] want;
        s_en  = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
        s_iv  = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        s_tag = '{1, 2, 9, 9, 3, 4, 9, 0, 0, 0};
        s_exp = '{0, 0, 0, 0, 1, 2, 2, 3, 4, 0};
        for (int t = 1; t <= 4; t++) begin
            ta[t] = $urandom(); tb[t] = $urandom(); top[t] = 2'($urandom_range(0, 3));
        end
        ta[0] = '0; tb[0] = '0; top[0] = '0;
        flush = 1'b0;
        for (int c = 0; c < 10; c++) begin
            en = s_en[c]; iv32 = s_iv[c]; tag32 = s_tag[c];
            if (s_tag[c] >= 1 && s_tag[c] <= 4) begin
                a32 = ta[s_tag[c]]; b32 = tb[s_tag[c]]; op32 = top[s_tag[c]];
            end else begin
                a32 = $urandom(); b32 = $urandom(); op32 = 2'($urandom_range(0, 3));
            end
            tick();
            n_checks++;
            if (s_exp[c] == 5'd0) begin
                if (ov32 !== 1'b0) begin
                    n_fail++; $display("FAIL stall_c%0d got v=%b exp v=0", c, ov32);
                end
            end else begin
                want = ref_mul(32, top[s_exp[c]], ta[s_exp[c]], tb[s_exp[c]]);
                if (ov32 !== 1'b1 || otag32 !== s_exp[c] || res32 !== want) begin
                    n_fail++;
                    $display("FAIL stall_c%0d got v=%b t=%0d r=%h exp v=1 t=%0d r=%h",
                             c, ov32, otag32, res32, s_exp[c], want);
                end
            end
            if (c == 2 || c == 3) begin
                n_checks++;
                if (busy32 !== 1'b1) begin
                    n_fail++; $display("FAIL stall_busy_c%0d got=%b exp=1", c, busy32);
                end
            end
        end
        en = 1'b1;
        idle_inputs();
    endtask

    task automatic test_flush();
        en = 1'b1; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            iv32 = 1'b1; op32 = 2'b00; a32 = 32'(c + 3); b32 = 32'd5; tag32 = 5'(c + 1);
            tick();
        end
        n_checks++;
        if (ov32 !== 1'b1 || res32 !== 32'd15) begin
            n_fail++; $display("FAIL flush_pre got v=%b r=%h exp v=1 r=0000000f", ov32, res32);
        end
        en = 1'b0; flush = 1'b1; iv32 = 1'b1; tag32 = 5'd31;
        tick();
        n_checks += 2;
        if (ov32 !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", ov32); end
        if (busy32 !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy32); end
        flush = 1'b0; en = 1'b1;
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (ov32 !== 1'b0 || busy32 !== 1'b0) begin
                n_fail++; $display("FAIL flush_after_c%0d got v=%b busy=%b exp v=0 busy=0", c, ov32, busy32);
            end
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            iv32 = 1'b1; op32 = 2'b11; a32 = 32'hDEAD0000 + 32'(c); b32 = 32'hBEEF; tag32 = 5'(c + 7);
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        #2;
        n_checks += 4;
        if (ov32 !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", ov32); end
        if (res32 !== 32'd0) begin n_fail++; $display("FAIL rstmid_result got=%h exp=0", res32); end
        if (otag32 !== 5'd0) begin n_fail++; $display("FAIL rstmid_tag got=%0d exp=0", otag32); end
        if (busy32 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy32); end
        #1;
        reset = 1'b0;
        iv32 = 1'b1; op32 = 2'b00; a32 = 32'd7; b32 = 32'd6; tag32 = 5'd5;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (ov32 !== 1'b0) begin n_fail++; $display("FAIL rstmid_early got v=%b exp v=0", ov32); end
        tick();
        n_checks++;
        if (ov32 !== 1'b1 || res32 !== 32'd42 || otag32 !== 5'd5) begin
            n_fail++; $display("FAIL rstmid_42 got v=%b r=%0d t=%0d exp v=1 r=42 t=5", ov32, res32, otag32);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] nv32, nv16, obs_r;
        logic        obs_v, obs_b, exp_v;
        logic [31:0] exp_r;
        logic [4:0]  obs_t, exp_t;
        flight_t     nq[$];
        flight_t     e;
        reset = 1'b1; idle_inputs(); en = 1'b1; flush = 1'b0;
        tick();
        reset = 1'b0;
        fq.delete();
        for (int c = 0; c < 6000; c++) begin
            en    = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 29) == 0);
            iv32 = ($urandom_range(0, 3) != 0); op32 = 2'($urandom_range(0, 3));
            a32 = rand_operand(32); b32 = rand_operand(32); tag32 = 5'($urandom_range(0, 31));
            iv16 = ($urandom_range(0, 3) != 0); op16 = 2'($urandom_range(0, 3));
            a16 = 16'(rand_operand(16)); b16 = 16'(rand_operand(16)); tag16 = 5'($urandom_range(0, 31));
            nv32 = ref_mul(32, op32, a32, b32);
            nv16 = ref_mul(16, op16, {16'd0, a16}, {16'd0, b16});
            @(posedge clk);
            if (flush) begin
                fq.delete();
            end else if (en) begin
                nq.delete();
                foreach (fq[i]) begin
                    if (fq[i].age < 3) begin
                        e = fq[i]; e.age++; nq.push_back(e);
                    end
                end
                fq = nq;
                if (iv32) begin e.dut = 0; e.res = nv32; e.tag = tag32; e.age = 1; fq.push_back(e); end
                if (iv16) begin e.dut = 1; e.res = nv16; e.tag = tag16; e.age = 1; fq.push_back(e); end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                exp_v = 1'b0; exp_r = '0; exp_t = '0; obs_b = 1'b0;
                foreach (fq[i]) begin
                    if (fq[i].dut == d) begin
                        obs_b = 1'b1;
                        if (fq[i].age == 3) begin exp_v = 1'b1; exp_r = fq[i].res; exp_t = fq[i].tag; end
                    end
                end
                obs_v = (d == 0) ? ov32 : ov16;
                obs_r = (d == 0) ? res32 : {16'd0, res16};
                obs_t = (d == 0) ? otag32 : otag16;
                n_checks++;
                if (obs_v !== exp_v || (exp_v && (obs_r !== exp_r || obs_t !== exp_t))) begin
                    n_fail++;
                    $display("FAIL rand_w%0d_c%0d got v=%b r=%h t=%0d exp v=%b r=%h t=%0d",
                             (d == 0) ? 32 : 16, c, obs_v, obs_r, obs_t, exp_v, exp_r, exp_t);
                end
                n_checks++;
                if (((d == 0) ? busy32 : busy16) !== obs_b) begin
                    n_fail++;
                    $display("FAIL rand_busy_w%0d_c%0d got=%b exp=%b",
                             (d == 0) ? 32 : 16, c, (d == 0) ? busy32 : busy16, obs_b);
                end
            end
        end
        idle_inputs(); en = 1'b1; flush = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_corners();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
